// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the intersection phase sequencer.
// Lamp vectors are {red, yellow, green}.
package traffic_pkg;

    typedef enum logic [2:0] {
        AR_A, NS_G, NS_Y, AR_B, EW_G, EW_Y, WALK, FLASH
    } tl_state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    function automatic int tl_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_phase_timer.sv
// Per-phase tick counter; done flags the counted tick that reaches limit.
module phase_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          count_en,
    input  logic          clr,
    input  logic [TW-1:0] limit,
    output logic          done
);

    logic [TW-1:0] count;

    assign done = count_en && (count == limit - TW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        count <= '0;
        else if (clr)      count <= '0;
        else if (count_en) count <= count + TW'(1);
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road phase sequencer driven by an external tick counter.
// Define TL_PED_EN to add the pedestrian request input and WALK phase.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_TICKS  = 5,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       flash,
`ifdef TL_PED_EN
    input  logic       ped_req,
`endif
    input  logic       tick_in,
    output logic       tick_en,
    output logic       tick_clr,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk
);

    localparam int MAXT = tl_max4(GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS, WALK_TICKS);
    localparam int TW   = $clog2(MAXT) + 1;

    tl_state_t     state_q, state_d;
    logic [TW-1:0] limit;
    logic          cnt_ok, tmr_en, tmr_done, blink;

    // A tick landing while the counter is being cleared belongs to no phase.
    assign cnt_ok = tick_in & run & ~tick_clr;
    assign tmr_en = cnt_ok & (state_q != FLASH);

    always_comb begin
        limit = TW'(ALLRED_TICKS);
        case (state_q)
            NS_G, EW_G: limit = TW'(GREEN_TICKS);
            NS_Y, EW_Y: limit = TW'(YELLOW_TICKS);
            WALK:       limit = TW'(WALK_TICKS);
            default:    limit = TW'(ALLRED_TICKS);
        endcase
    end

    phase_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .count_en (tmr_en),
        .clr      (state_d != state_q),
        .limit    (limit),
        .done     (tmr_done)
    );

`ifdef TL_PED_EN
    logic ped_pend, next_ns, enter_walk;
    assign enter_walk = (state_d == WALK) && (state_q != WALK);
`endif

    always_comb begin
        state_d = state_q;
        if (flash)
            state_d = FLASH;
        else if (state_q == FLASH)
            state_d = AR_A;
        else if (tmr_done) begin
            case (state_q)
`ifdef TL_PED_EN
                AR_A:    state_d = ped_pend ? WALK : NS_G;
                AR_B:    state_d = ped_pend ? WALK : EW_G;
                WALK:    state_d = next_ns ? NS_G : EW_G;
`else
                AR_A:    state_d = NS_G;
                AR_B:    state_d = EW_G;
`endif
                NS_G:    state_d = NS_Y;
                NS_Y:    state_d = AR_B;
                EW_G:    state_d = EW_Y;
                EW_Y:    state_d = AR_A;
                default: state_d = AR_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= AR_A;
            tick_en  <= 1'b0;
            tick_clr <= 1'b1;
            blink    <= 1'b1;
        end else begin
            state_q  <= state_d;
            tick_en  <= run | flash;
            tick_clr <= (state_d != state_q);
            if (state_d == FLASH && state_q != FLASH)
                blink <= 1'b1;
            else if (state_q == FLASH && cnt_ok)
                blink <= ~blink;
        end
    end

`ifdef TL_PED_EN
    // Requests seen during WALK or on its entry edge are already being served.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ped_pend <= 1'b0;
            next_ns  <= 1'b1;
        end else begin
            if (enter_walk)
                ped_pend <= 1'b0;
            else if (ped_req && state_q != WALK)
                ped_pend <= 1'b1;
            if (enter_walk)
                next_ns <= (state_q == AR_A);
        end
    end

    assign walk = (state_q == WALK);
`else
    assign walk = 1'b0;
`endif

    always_comb begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
        case (state_q)
            NS_G:    ns_light = LAMP_GRN;
            NS_Y:    ns_light = LAMP_YEL;
            EW_G:    ew_light = LAMP_GRN;
            EW_Y:    ew_light = LAMP_YEL;
            FLASH: begin
                ns_light = blink ? LAMP_YEL : LAMP_OFF;
                ew_light = blink ? LAMP_YEL : LAMP_OFF;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a phase-list model. Honors TL_PED_EN.
module tb_traffic_light_ctrl;

    localparam int GREEN_T = 5, YELLOW_T = 2, ALLRED_T = 1, WALK_T = 4;
`ifdef TL_PED_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, run, flash, ped_req, tick_in;
    logic       tick_en, tick_clr, walk;
    logic [2:0] ns_light, ew_light;

    int  n_checks = 0;
    int  n_err    = 0;
    bit  running  = 1'b1;

    traffic_light_ctrl dut (
        .clk      (clk),
        .reset    (rst_n),
        .run      (run),
        .flash    (flash),
`ifdef TL_PED_EN
        .ped_req  (ped_req),
`endif
        .tick_in  (tick_in),
        .tick_en  (tick_en),
        .tick_clr (tick_clr),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .walk     (walk)
    );

    always #5 clk = ~clk;

    // Model: position in the six-phase ring, plus walk/flash overlays.
    int m_ph, m_cnt, m_res;
    bit m_walk, m_fl, m_blink, m_pend, m_clr, m_en;

    function automatic int phase_len(input int ph);
        if (ph % 3 == 0) return ALLRED_T;
        if (ph % 3 == 1) return GREEN_T;
        return YELLOW_T;
    endfunction

    function automatic logic [5:0] ring_lamps(input int ph);
        case (ph)
            1:       return 6'b001_100;
            2:       return 6'b010_100;
            4:       return 6'b100_001;
            5:       return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    function automatic logic [8:0] model_out();
        logic [5:0] l;
        logic       w;
        w = 1'b0;
        if (m_fl)        l = m_blink ? 6'b010_010 : 6'b000_000;
        else if (m_walk) begin l = 6'b100_100; w = 1'b1; end
        else             l = ring_lamps(m_ph);
        return {l, w, m_en, m_clr};
    endfunction

    task automatic model_reset();
        m_ph = 0; m_cnt = 0; m_res = 1; m_walk = 0; m_fl = 0;
        m_blink = 1; m_pend = 0; m_clr = 1; m_en = 0;
    endtask

    task automatic model_update();
        bit counted, was_walk, changed, entering;
        counted  = tick_in && run && !m_clr;
        was_walk = m_walk;
        changed  = 0;
        entering = 0;
        if (flash) begin
            if (!m_fl) begin m_fl = 1; m_walk = 0; m_blink = 1; changed = 1; end
            else if (counted) m_blink = !m_blink;
        end else if (m_fl) begin
            m_fl = 0; m_ph = 0; changed = 1;
        end else if (counted) begin
            m_cnt++;
            if (m_cnt == (m_walk ? WALK_T : phase_len(m_ph))) begin
                changed = 1;
                if (m_walk) begin m_walk = 0; m_ph = m_res; end
                else if (PED && m_pend && m_ph % 3 == 0) begin
                    m_walk = 1; entering = 1; m_res = m_ph + 1;
                end else m_ph = (m_ph + 1) % 6;
            end
        end
        if (entering) m_pend = 0;
        else if (PED && ped_req && !was_walk) m_pend = 1;
        if (changed) m_cnt = 0;
        m_clr = changed;
        m_en  = run || flash;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_update();
        #1;
    endtask

    task automatic set_reset(input logic v);
        rst_n = v;
        if (!v) model_reset();
    endtask

    task automatic tick();
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
        repeat (3) step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    initial begin
        while (running) begin
            @(negedge clk);
            if (running)
                chk("model", {ns_light, ew_light, walk, tick_en, tick_clr}, model_out());
        end
    end

    initial begin
        run = 1'b1; flash = 1'b0; ped_req = 1'b0; tick_in = 1'b0;
        set_reset(1'b0);
        step();
        chk("reset_vals", {ns_light, ew_light, walk, tick_en, tick_clr}, 9'b100100_0_0_1);
        step();
        set_reset(1'b1);
        step();
        chk("first_edge", {7'd0, tick_en, tick_clr}, 9'b10);

        // AR_A expires after one tick; the held tick_in is masked by tick_clr.
        tick_in = 1'b1;
        step();
        chk("ns_g_entry", {ns_light, ew_light, 2'b00, tick_clr}, 9'b001100_00_1);
        step();
        tick_in = 1'b0;
        repeat (2) step();
        ticks(2);

        run = 1'b0;
        ticks(5);
        chk("run0_hold", {ns_light, ew_light, walk, tick_en, tick_clr}, 9'b001100_0_0_0);
        run = 1'b1;
        step();
        ticks(2);
        chk("ns_g_4th", {3'd0, ns_light, ew_light}, 9'b001100);
        tick();
        chk("ns_y", {3'd0, ns_light, ew_light}, 9'b010100);
        ticks(2);
        chk("ar_b", {3'd0, ns_light, ew_light}, 9'b100100);
        tick();
        chk("ew_g", {3'd0, ns_light, ew_light}, 9'b100001);

        flash = 1'b1;
        step();
        chk("flash_on", {3'd0, ns_light, ew_light}, 9'b010010);
        step();
        tick();
        chk("flash_blink0", {3'd0, ns_light, ew_light}, 9'b000000);
        tick();
        chk("flash_blink1", {3'd0, ns_light, ew_light}, 9'b010010);
        flash = 1'b0;
        step();
        chk("flash_off", {2'd0, ns_light, ew_light, walk}, 9'b1001000);
        step();

        ticks(6);
        chk("ns_y_again", {3'd0, ns_light, ew_light}, 9'b010100);
        tick();
        set_reset(1'b0);
        #1;
        chk("async_reset", {ns_light, ew_light, walk, tick_en, tick_clr}, 9'b100100_0_0_1);
        step();
        set_reset(1'b1);
        step();
        tick();
        chk("restart_ns_g", {3'd0, ns_light, ew_light}, 9'b001100);

`ifdef TL_PED_EN
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        ticks(5 + 2 + 1);
        chk("walk_on", {2'd0, ns_light, ew_light, walk}, 9'b1001001);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        ticks(3);
        chk("walk_hold", {2'd0, ns_light, ew_light, walk}, 9'b1001001);
        tick();
        chk("walk_to_ew_g", {2'd0, ns_light, ew_light, walk}, 9'b1000010);
        ticks(5 + 2 + 1);
        chk("no_second_walk", {2'd0, ns_light, ew_light, walk}, 9'b0011000);
`endif

        for (int c = 0; c < 4000; c++) begin
            if (!rst_n) set_reset(1'b1);
            else if ($urandom_range(0, 699) == 0) set_reset(1'b0);
            run = ($urandom_range(0, 7) != 0);
            if (!flash && $urandom_range(0, 299) == 0) flash = 1'b1;
            else if (flash && $urandom_range(0, 39) == 0) flash = 1'b0;
            ped_req = ($urandom_range(0, 29) == 0);
            tick_in = (c < 2000) ? (c % 4 == 3) : ($urandom_range(0, 2) == 0);
            step();
        end
        set_reset(1'b1);
        run = 1'b1; flash = 1'b0; ped_req = 1'b0; tick_in = 1'b0;
        repeat (4) step();

        running = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
